// File: rtl/timetag_pkg.sv
// Shared widths, serializer state encoding and record packing for the
// timetag event packer.
package timetag_pkg;

   localparam int REC_W         = 47;
   localparam int WORD_W        = 16;
   localparam int WORDS_PER_REC = 3;
   localparam int PKT_W         = WORD_W * WORDS_PER_REC;
   localparam int LOST_BIT      = 47;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W0   = 2'd1,
      W1   = 2'd2,
      W2   = 2'd3
   } ser_state_e;

   // The lost flag rides in the top bit, so it lands in bit 15 of the first word.
   function automatic logic [PKT_W-1:0] pack_record(input logic             lost,
                                                    input logic [REC_W-1:0] rec);
      logic [PKT_W-1:0] p;
      p           = {PKT_W{1'b0}};
      p[REC_W-1:0] = rec;
      p[LOST_BIT] = lost;
      return p;
   endfunction

endpackage

// File: rtl/record_fifo.sv
// Record FIFO: synchronous write into a register array, head entry read from
// that array and captured by the consumer on pop.
module record_fifo
   import timetag_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = REC_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             wr_ok_s;
   logic             rd_ok_s;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == {LW{1'b0}});
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; a write is judged on the pre-pop level.
   always_comb begin
      wr_ok_s  = wr_en_i && !full_o;
      rd_ok_s  = rd_en_i && !empty_o;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_ok_s, rd_ok_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are meaningless once the pointers are reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/event_packer.sv
// Buffers tagger records and serializes each as three 16-bit words, flagging
// the first record after any overflow gap and counting dropped records.
module event_packer
   import timetag_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int LOST_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   rec_rdy,
   input  logic [REC_W-1:0]       rec_data,
   output logic [WORD_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   clear_lost,
   output logic [LOST_W-1:0]      lost_count,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int LW = $clog2(DEPTH) + 1;

   ser_state_e        state_q, state_d;
   logic [PKT_W-1:0]  shreg_q, shreg_d;
   logic              valid_q, valid_d;
   logic              pending_q, pending_d;
   logic [LOST_W-1:0] lost_q, lost_d;

   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [REC_W-1:0]  fifo_rd_data_s;
   logic [LW-1:0]     fifo_level_s;
   logic              drop_s;
   logic              load_s;
   logic              hs_s;

   record_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (rec_rdy),
      .wr_data_i (rec_data),
      .rd_en_i   (load_s),
      .rd_data_o (fifo_rd_data_s),
      .full_o    (fifo_full_s),
      .empty_o   (fifo_empty_s),
      .level_o   (fifo_level_s)
   );

   assign drop_s     = rec_rdy && fifo_full_s;
   assign hs_s       = valid_q && out_ready;
   assign out_valid  = valid_q;
   assign out_data   = shreg_q[PKT_W-1 -: WORD_W];
   assign lost_count = lost_q;
   assign fifo_level = fifo_level_s;

   // Serializer next state: shift on each accepted word, reload gaplessly after W2.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      load_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               load_s = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         W0, W1: begin
            if (hs_s) begin
               state_d = (state_q == W0) ? W1 : W2;
               shreg_d = {shreg_q[PKT_W-WORD_W-1:0], {WORD_W{1'b0}}};
            end else begin
               state_d = state_q;
            end
         end
         W2: begin
            if (hs_s && !fifo_empty_s) begin
               load_s = 1'b1;
            end else if (hs_s) begin
               state_d = IDLE;
            end else begin
               state_d = W2;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_s) begin
         shreg_d = pack_record(pending_q, fifo_rd_data_s);
         state_d = W0;
      end else begin
         shreg_d = shreg_d;
      end
      valid_d = (state_d != IDLE);
   end

   // Gap flag and saturating drop counter; a drop wins over a same-cycle load or clear.
   always_comb begin
      pending_d = pending_q;
      lost_d    = lost_q;
      if (drop_s) begin
         pending_d = 1'b1;
      end else if (load_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (clear_lost) begin
         lost_d = drop_s ? LOST_W'(1) : {LOST_W{1'b0}};
      end else if (drop_s && (lost_q != {LOST_W{1'b1}})) begin
         lost_d = lost_q + LOST_W'(1);
      end else begin
         lost_d = lost_q;
      end
   end

   // Serializer, flag and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shreg_q   <= {PKT_W{1'b0}};
         valid_q   <= 1'b0;
         pending_q <= 1'b0;
         lost_q    <= {LOST_W{1'b0}};
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
         lost_q    <= lost_d;
      end
   end

endmodule

// File: tb/tb_event_packer.sv
// Directed scoreboard bench for event_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_event_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rec_rdy;
   logic [46:0] rec_data;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        clear_lost;
   logic [15:0] lost_count;
   logic [4:0]  fifo_level;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q [$];

   logic        hold_v;
   logic [15:0] hold_d;
   logic        trk_clr;
   int          run_len, max_run, peak_lvl;

   always #5 clk = ~clk;

   event_packer #(.DEPTH(16), .LOST_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rec_rdy    (rec_rdy),
      .rec_data   (rec_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .clear_lost (clear_lost),
      .lost_count (lost_count),
      .fifo_level (fifo_level)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [46:0] pat(input int i);
      return {15'(16'h6A00 + i), 16'(16'hC000 + i), 16'(16'h0F00 + i)};
   endfunction

   task automatic exp_rec(input logic lost, input logic [46:0] d);
      logic [47:0] p;
      p = {lost, d};
      exp_q.push_back(p[47:32]);
      exp_q.push_back(p[31:16]);
      exp_q.push_back(p[15:0]);
   endtask

   task automatic send(input logic [46:0] d);
      rec_rdy  = 1'b1;
      rec_data = d;
      @(posedge clk);
      #1 rec_rdy = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc);
      int k;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      if (!out_valid) chk("wait_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic wait_drain(input int max_cyc);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout_words_left", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: compare accepted words and require stability while stalled.
   always @(negedge clk) begin
      if (!reset_n) begin
         hold_v <= 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_d));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
               chk("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
         end
         hold_v <= out_valid && !out_ready;
         hold_d <= out_data;
      end
   end

   // Longest out_valid run and peak FIFO level since the last trk_clr.
   always @(negedge clk) begin
      if (trk_clr) begin
         run_len  <= 0;
         max_run  <= 0;
         peak_lvl <= 0;
      end else begin
         run_len <= out_valid ? run_len + 1 : 0;
         if (out_valid && (run_len + 1 > max_run)) max_run <= run_len + 1;
         if (int'(fifo_level) > peak_lvl) peak_lvl <= int'(fifo_level);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [47:0] p;
      reset_n = 1'b0; rec_rdy = 1'b0; rec_data = 47'h0;
      out_ready = 1'b1; clear_lost = 1'b0; trk_clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_lost", 32'(lost_count), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      trk_clr = 1'b0;
      @(posedge clk); #1;

      // Single record, latency two cycles
      exp_q.push_back(16'h1234); exp_q.push_back(16'h5678); exp_q.push_back(16'h9ABC);
      send(47'h1234_5678_9ABC);
      @(negedge clk) chk("lat_t1_valid", 32'(out_valid), 32'd0);
      @(negedge clk) chk("lat_t2_valid", 32'(out_valid), 32'd1);
      chk("lat_t2_w0", 32'(out_data), 32'h1234);
      wait_drain(20);
      chk("single_level", 32'(fifo_level), 32'd0);
      chk("single_idle", 32'(out_valid), 32'd0);

      // Backpressure on W0 for five cycles
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_q.push_back(16'h1234); exp_q.push_back(16'h5678); exp_q.push_back(16'h9ABC);
      send(47'h1234_5678_9ABC);
      wait_valid(10);
      chk("bp_w0", 32'(out_data), 32'h1234);
      repeat (4) begin
         @(negedge clk) chk("bp_w0_held", 32'(out_data), 32'h1234);
      end
      out_ready = 1'b1;
      wait_drain(20);

      // Streaming four back-to-back records
      trk_clr = 1'b1;
      @(negedge clk);
      #1 trk_clr = 1'b0;
      @(posedge clk); #1;
      for (int i = 1; i <= 4; i++) exp_rec(1'b0, pat(i));
      for (int i = 1; i <= 4; i++) send(pat(i));
      wait_drain(40);
      @(negedge clk);
      chk("stream_run", 32'(max_run), 32'd12);
      chk("stream_peak_level", 32'(peak_lvl), 32'd3);

      // Overflow: one record parks in the serializer, 16 fill the FIFO, 2 drop
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 1; i <= 17; i++) exp_rec(i == 2, pat(100 + i));
      for (int i = 1; i <= 19; i++) send(pat(100 + i));
      @(negedge clk);
      chk("ovf_level", 32'(fifo_level), 32'd16);
      chk("ovf_lost", 32'(lost_count), 32'd2);
      out_ready = 1'b1;
      wait_drain(200);
      chk("ovf_drained_level", 32'(fifo_level), 32'd0);

      // Counter: clear alone, saturate, clear coinciding with a drop
      @(posedge clk); #1;
      clear_lost = 1'b1;
      @(posedge clk); #1 clear_lost = 1'b0;
      @(negedge clk) chk("clear_alone", 32'(lost_count), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 1; i <= 17; i++) exp_rec(i == 2, pat(300 + i));
      for (int i = 1; i <= 17; i++) send(pat(300 + i));
      rec_rdy  = 1'b1;
      rec_data = pat(999);
      repeat (65534) @(posedge clk);
      #1 rec_rdy = 1'b0;
      @(negedge clk) chk("lost_fffe", 32'(lost_count), 32'h0000_FFFE);
      send(pat(998));
      @(negedge clk) chk("lost_ffff", 32'(lost_count), 32'h0000_FFFF);
      send(pat(997));
      @(negedge clk) chk("lost_saturated", 32'(lost_count), 32'h0000_FFFF);
      @(posedge clk); #1;
      clear_lost = 1'b1;
      send(pat(996));
      clear_lost = 1'b0;
      @(negedge clk) chk("clear_with_drop", 32'(lost_count), 32'd1);
      out_ready = 1'b1;
      wait_drain(200);

      // Reset asserted while W1 of the first of three records is on the bus
      @(posedge clk); #1;
      for (int i = 1; i <= 3; i++) exp_rec(1'b0, pat(200 + i));
      for (int i = 1; i <= 3; i++) send(pat(200 + i));
      p = {1'b0, pat(201)};
      chk("pre_rst_w1", 32'(out_data), 32'(p[31:16]));
      chk("pre_rst_level", 32'(fifo_level), 32'd2);
      chk("pre_rst_lost", 32'(lost_count), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_lost", 32'(lost_count), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      exp_rec(1'b0, pat(210));
      send(pat(210));
      wait_valid(10);
      p = {1'b0, pat(210)};
      chk("post_rst_w0", 32'(out_data), 32'(p[47:32]));
      wait_drain(20);
      chk("post_rst_level", 32'(fifo_level), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
